// File: rtl/jk_pkg.sv
// Shared types for the JK/T/D/SR register bank.
// Mode encoding and popcount sizing helper.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE = 2'b00,
    T_MODE  = 2'b01,
    D_MODE  = 2'b10,
    SR_MODE = 2'b11
  } jk_mode_e;

  function automatic int pcnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int PCNT_W = pcnt_w(8);

endpackage

// File: rtl/jk_bit_cell.sv
// Next-state logic for one flip-flop of the bank.
// Flags S=R=1 in SR mode as illegal and holds the bit.
module jk_bit_cell
  import jk_pkg::*;
(
  input  logic     q,
  input  logic     j,
  input  logic     k,
  input  jk_mode_e mode,
  output logic     q_next,
  output logic     illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    unique case (1'b1)
      (mode == JK_MODE): begin
        unique case ({j, k})
          2'b00: q_next = q;
          2'b01: q_next = 1'b0;
          2'b10: q_next = 1'b1;
          2'b11: q_next = ~q;
        endcase
      end
      (mode == T_MODE): q_next = j ? ~q : q;
      (mode == D_MODE): q_next = j;
      (mode == SR_MODE): begin
        unique case ({j, k})
          2'b00: q_next = q;
          2'b01: q_next = 1'b0;
          2'b10: q_next = 1'b1;
          2'b11: begin
            q_next  = q;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of per-bit JK/T/D/SR flip-flops with parallel load,
// sticky SR-illegal flag and saturating bit-change counter.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             sr_err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam int PW = pcnt_w(WIDTH);
  // Sum is one bit wider than the larger operand so it can never wrap.
  localparam int SW = ((PW > CNT_W) ? PW : CNT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_cell;
  logic [WIDTH-1:0] ill_v;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] diff;
  logic [PW-1:0]    pc;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt_nxt;
  logic             set_err;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_bit_cell u_cell (
      .q      (Q[i]),
      .j      (J[i]),
      .k      (K[i]),
      .mode   (jk_mode_e'(mode)),
      .q_next (q_cell[i]),
      .illegal(ill_v[i])
    );
  end

  always_comb begin
    q_nxt = Q;
    if (load)
      q_nxt = load_data;
    else if (en)
      q_nxt = q_cell;
  end

  assign set_err = en & ~load & (|ill_v);
  assign diff    = q_nxt ^ Q;

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++)
      pc = pc + PW'(diff[i]);
  end

  assign sum     = SW'(chg_cnt) + SW'(pc);
  assign cnt_nxt = (sum > SW'(CNT_MAX)) ? CNT_MAX
                                        : sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q       <= RST_VAL;
      sr_err  <= 1'b0;
      chg_cnt <= '0;
    end else begin
      Q       <= q_nxt;
      sr_err  <= set_err | (sr_err & ~clr_err);
      chg_cnt <= cnt_nxt;
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: directed table,
// multi-cycle corner sequences and random vs reference model.
module tb_jk_reg_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] J;
  logic [7:0] K;
  logic       clr_err;

  logic [7:0] qa, qna, ca;
  logic       ea;
  logic [7:0] qb, qnb, cb;
  logic       eb;
  logic [7:0] qc, qnc;
  logic [3:0] cc;
  logic       ec;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq   [3];
  logic       merr [3];
  int         mcnt [3];
  int         mmax [3];
  logic [7:0] mrst [3];

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic       load;
    logic [7:0] ld;
    logic [7:0] j;
    logic [7:0] k;
    logic       clr;
    logic [7:0] eq;
    logic       ee;
    logic [7:0] ec;
  } vec_t;

  vec_t vec [13];

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .load_data(load_data), .J(J), .K(K), .clr_err(clr_err),
    .Q(qa), .Qn(qna), .sr_err(ea), .chg_cnt(ca)
  );

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .load_data(load_data), .J(J), .K(K), .clr_err(clr_err),
    .Q(qb), .Qn(qnb), .sr_err(eb), .chg_cnt(cb)
  );

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .load_data(load_data), .J(J), .K(K), .clr_err(clr_err),
    .Q(qc), .Qn(qnc), .sr_err(ec), .chg_cnt(cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mq[d]   = mrst[d];
      merr[d] = 1'b0;
      mcnt[d] = 0;
    end
  endtask

  // Characteristic equations per mode, applied to whole words.
  task automatic model_step();
    logic [7:0] q, nx, s, r;
    logic       ill;
    int         c;
    for (int d = 0; d < 3; d++) begin
      q   = mq[d];
      ill = 1'b0;
      if (load)
        nx = load_data;
      else if (!en)
        nx = q;
      else begin
        case (mode)
          2'd0: nx = (J & ~q) | (~K & q);
          2'd1: nx = q ^ J;
          2'd2: nx = J;
          default: begin
            s   = J & ~K;
            r   = K & ~J;
            nx  = (q | s) & ~r;
            ill = |(J & K);
          end
        endcase
      end
      c = mcnt[d] + $countones(nx ^ q);
      mcnt[d] = (c > mmax[d]) ? mmax[d] : c;
      merr[d] = ill | (merr[d] & ~clr_err);
      mq[d]   = nx;
    end
  endtask

  task automatic check_all();
    logic [7:0] inv;
    inv = ~mq[0];
    chk("q_a", 32'(qa), 32'(mq[0]));
    chk("qn_a", 32'(qna), 32'(inv));
    chk("err_a", 32'(ea), 32'(merr[0]));
    chk("cnt_a", 32'(ca), mcnt[0]);
    inv = ~mq[1];
    chk("q_b", 32'(qb), 32'(mq[1]));
    chk("qn_b", 32'(qnb), 32'(inv));
    chk("err_b", 32'(eb), 32'(merr[1]));
    chk("cnt_b", 32'(cb), mcnt[1]);
    inv = ~mq[2];
    chk("q_c", 32'(qc), 32'(mq[2]));
    chk("qn_c", 32'(qnc), 32'(inv));
    chk("err_c", 32'(ec), 32'(merr[2]));
    chk("cnt_c", 32'(cc), mcnt[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [1:0] m, input logic e,
                       input logic l, input logic [7:0] ld,
                       input logic [7:0] j, input logic [7:0] k,
                       input logic c);
    mode = m; en = e; load = l; load_data = ld;
    J = j; K = k; clr_err = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mmax = '{255, 255, 15};
    mrst = '{8'hA5, 8'h00, 8'h00};
    rst_n = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    model_reset();

    //         mode  en    load  ld     J      K      clr   Q      err   cnt
    vec[0]  = '{2'd0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 8'd8};
    vec[1]  = '{2'd0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8'd16};
    vec[2]  = '{2'd0, 1'b1, 1'b0, 8'h00, 8'h0F, 8'hF0, 1'b0, 8'h0F, 1'b0, 8'd20};
    vec[3]  = '{2'd1, 1'b1, 1'b0, 8'h00, 8'h33, 8'h00, 1'b0, 8'h3C, 1'b0, 8'd24};
    vec[4]  = '{2'd2, 1'b1, 1'b0, 8'h00, 8'hC3, 8'h00, 1'b0, 8'hC3, 1'b0, 8'd32};
    vec[5]  = '{2'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'hC3, 1'b0, 8'd32};
    vec[6]  = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'd36};
    vec[7]  = '{2'd3, 1'b1, 1'b0, 8'h00, 8'h03, 8'h01, 1'b0, 8'h02, 1'b1, 8'd37};
    vec[8]  = '{2'd3, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h02, 1'b0, 8'd37};
    vec[9]  = '{2'd3, 1'b1, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1, 8'h02, 1'b1, 8'd37};
    vec[10] = '{2'd3, 1'b1, 1'b1, 8'h5A, 8'hFF, 8'hFF, 1'b0, 8'h5A, 1'b1, 8'd40};
    vec[11] = '{2'd3, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h5A, 1'b1, 8'd40};
    vec[12] = '{2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b0, 8'd40};

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", 32'(qa), 32'h0000_00A5);
    chk("rst_qn", 32'(qna), 32'h0000_005A);
    chk("rst_cnt", 32'(ca), 32'd0);
    chk("rst_err", 32'(ea), 32'd0);
    chk("rst_qb", 32'(qb), 32'd0);
    rst_n = 1'b1;

    // Directed table, expected values for the RST_VAL=0 bank.
    for (int i = 0; i < 13; i++) begin
      drive(vec[i].mode, vec[i].en, vec[i].load, vec[i].ld,
            vec[i].j, vec[i].k, vec[i].clr);
      tick();
      chk($sformatf("vec%0d_q", i), 32'(qb), 32'(vec[i].eq));
      chk($sformatf("vec%0d_err", i), 32'(eb), 32'(vec[i].ee));
      chk($sformatf("vec%0d_cnt", i), 32'(cb), 32'(vec[i].ec));
    end

    // Async reset mid-cycle with a load pending.
    drive(2'd1, 1'b1, 1'b1, 8'h3C, 8'hFF, 8'h00, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_q", 32'(qa), 32'h0000_00A5);
    chk("mid_rst_qn", 32'(qna), 32'h0000_005A);
    chk("mid_rst_cnt", 32'(ca), 32'd0);
    chk("mid_rst_err", 32'(ea), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_q", 32'(qa), 32'h0000_00A5);
    chk("rst_hold_qb", 32'(qb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation on the 4-bit counter: 8, 15, 15.
    drive(2'd1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
    tick();
    chk("sat1_cnt", 32'(cc), 32'd8);
    chk("sat1_q", 32'(qa), 32'h0000_005A);
    tick();
    chk("sat2_cnt", 32'(cc), 32'd15);
    chk("sat2_q", 32'(qa), 32'h0000_00A5);
    tick();
    chk("sat3_cnt", 32'(cc), 32'd15);
    chk("sat3_cntb", 32'(cb), 32'd24);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0),
            8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised multi-bit successor to the single JK flip-flop: a bank of WIDTH flip-flops sharing one clock, reset, enable and runtime-selectable mode. Each bit can behave as JK, T, D or SR. The bank also supports synchronous parallel load, a sticky SR-illegal error flag and a saturating bit-change counter. It sits wherever the design needs a small control/status register with per-bit set/clear/toggle semantics.

## Interface
Parameters:
- WIDTH, 8, number of flip-flops in the bank (≥1)
- RST_VAL, 0, WIDTH-bit value Q takes on reset
- CNT_W, 8, width of change counter (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  update enable; 0 = hold all bits
- mode  in  2  00 JK, 01 T, 10 D, 11 SR
- load  in  1  synchronous parallel load, priority over en
- load_data  in  WIDTH  value written on load
- J  in  WIDTH  per-bit J / T / D / S input (by mode)
- K  in  WIDTH  per-bit K / – / – / R input (by mode; ignored in T and D)
- clr_err  in  1  clears sr_err synchronously
- Q  out  WIDTH  register state
- Qn  out  WIDTH  ~Q, combinational from Q
- sr_err  out  1  sticky: some bit had S=R=1 in SR mode while enabled
- chg_cnt  out  CNT_W  saturating count of bit transitions since reset

## Operation
- Reset (rst_n=0, async): Q=RST_VAL, Qn=~RST_VAL, sr_err=0, chg_cnt=0. All held while rst_n low; first update on first rising edge after release.
- Priority per edge: load > en > hold.
- load=1: Q<=load_data regardless of en/mode; sr_err is not set on this edge.
- en=1, load=0, per bit i:
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - T: J[i]=1 toggle, else hold.
  - D: Q[i]<=J[i].
  - SR: 10 set, 01 clear, 00 hold, 11 illegal → hold that bit, set sr_err.
- en=0, load=0: Q holds; sr_err not set.
- sr_err: set when any bit is illegal on an enabled SR edge. clr_err clears it. On the same edge, set wins over clr_err.
- chg_cnt: each edge adds popcount(Q_next ^ Q), with the popcount taken at $clog2(WIDTH+1) bits. Saturates at 2^CNT_W−1 and never wraps. Load transitions count. Reset is the only clear.
- mode changes take effect on the very edge they are sampled; no pipeline.

## Timing
- Latency one cycle: inputs sampled at edge n, Q valid after edge n.
- Qn has zero latency relative to Q.
- chg_cnt and sr_err update on the same edge as the Q change they describe.
- Reset asserted mid-operation overrides everything immediately, including a pending load or clr_err.
- Saturation boundary: the sum is computed at CNT_W+1 bits. If it exceeds the max, clamp. An increment that would pass the max lands exactly on the max.

## Structure
- Shared package jk_pkg:
  - mode enum `jk_mode_e` (JK_MODE, T_MODE, D_MODE, SR_MODE) on 2 bits.
  - localparam for popcount width.
- Sub-module `jk_bit_cell`: combinational next-state for one bit plus illegal flag.
  - Inputs: q, j, k, mode.
  - Outputs: q_next, illegal.
  - Instantiated WIDTH times by generate.
- Top holds the Q register, load/enable muxing, OR-reduce of the illegal flags, popcount and saturating counter.

## Test plan
- Reset: RST_VAL=8'hA5, hold rst_n=0 two cycles → Q=A5, Qn=5A, chg_cnt=0, sr_err=0.
  - Assert rst_n low mid-cycle later → Q=A5 before the next edge.
- JK mode, Q=00, en=1:
  - J=FF, K=00 → Q=FF, chg_cnt=8.
  - J=FF, K=FF → Q=00, chg_cnt=16.
  - J=0F, K=F0 → Q=0F, chg_cnt=20.
- T/D mode:
  - T, Q=0F, J=33 → Q=3C.
  - D, J=C3 → Q=C3.
  - en=0 with J=00 → Q stays C3.
- SR illegal, Q=00:
  - J=03, K=01 → Q=02, sr_err=1.
  - Next edge clr_err=1 with J=K=00 → sr_err=0.
  - clr_err together with an illegal bit → sr_err stays 1.
- Load priority: load=1, load_data=5A, en=1, mode=SR, J=K=FF → Q=5A, sr_err unchanged.
- Saturation: CNT_W=4, toggle all 8 bits each edge in T mode → chg_cnt 8, then 15, then stays 15.
